// File: rtl/ldtu_pkg.sv
// Shared LiteDTU framer definitions: states, trailer IDs, default widths and CRC-12 matrix.
package ldtu_pkg;

  localparam int unsigned LDTU_W         = 32;
  localparam int unsigned LDTU_SBITS     = 8;
  localparam int unsigned CRC_W          = 12;
  localparam int unsigned LDTU_FBITS     = 8;
  localparam int unsigned LDTU_CNT_BITS  = 6;
  localparam int unsigned LDTU_LOST_BITS = 16;

  localparam logic [LDTU_W-1:0] LDTU_INITIAL = 32'hF000_0000;
  localparam logic [3:0]        ID_OK        = 4'b1101;
  localparam logic [3:0]        ID_LOSS      = 4'b1110;
  localparam logic [CRC_W-1:0]  CRC_POLY     = 12'h80F;

  typedef enum logic [1:0] {COLLECT, PEND, FB} state_e;

  typedef logic [LDTU_W-1:0][CRC_W-1:0] crc_dmat_t;
  typedef logic [CRC_W-1:0][CRC_W-1:0]  crc_cmat_t;

  // Reference MSB-first shift used only to build the XOR matrices at elaboration.
  function automatic logic [CRC_W-1:0] crc_shift(input logic [LDTU_W-1:0] d,
                                                 input logic [CRC_W-1:0]  c);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = LDTU_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return r;
  endfunction

  function automatic crc_dmat_t crc_dmat_build();
    crc_dmat_t m;
    for (int j = 0; j < LDTU_W; j++) m[j] = crc_shift(LDTU_W'(1) << j, '0);
    return m;
  endfunction

  function automatic crc_cmat_t crc_cmat_build();
    crc_cmat_t m;
    for (int k = 0; k < CRC_W; k++) m[k] = crc_shift('0, CRC_W'(1) << k);
    return m;
  endfunction

  localparam crc_dmat_t CRC_DMAT = crc_dmat_build();
  localparam crc_cmat_t CRC_CMAT = crc_cmat_build();

endpackage

// File: rtl/ldtu_crc_step.sv
// Combinational CRC-12 update for one data word; linear XOR of matrix columns.
module ldtu_crc_step
  import ldtu_pkg::*;
(
  input  logic [LDTU_W-1:0] data,
  input  logic [CRC_W-1:0]  crc,
  output logic [CRC_W-1:0]  crc_next_c
);

  always_comb begin
    crc_next_c = '0;
    for (int j = 0; j < LDTU_W; j++)
      if (data[j]) crc_next_c = crc_next_c ^ CRC_DMAT[j];
    for (int k = 0; k < CRC_W; k++)
      if (crc[k]) crc_next_c = crc_next_c ^ CRC_CMAT[k];
  end

endmodule

// File: rtl/ldtu_sample_weight.sv
// Combinational sample weight from the 8-bit type/sample code of a compressed word.
module ldtu_sample_weight (
  input  logic [7:0] code,
  output logic [5:0] weight_c
);

  always_comb begin
    weight_c = '0;
    unique case (code[7:6])
      2'b01:   weight_c = 6'd5;
      2'b10:   weight_c = code[5:0];
      2'b00:   weight_c = (code[7:2] == 6'b001010) ? 6'd2 : 6'd1;
      default: weight_c = '0;
    endcase
  end

endmodule

// File: rtl/ldtu_framer_gen2.sv
// LiteDTU framing control unit: forwards words to the FIFO and closes frames with a trailer.
module ldtu_framer_gen2
  import ldtu_pkg::*;
#(
  parameter int unsigned W         = LDTU_W,
  parameter int unsigned SBITS     = LDTU_SBITS,
  parameter int unsigned CRC_BITS  = CRC_W,
  parameter int unsigned FBITS     = LDTU_FBITS,
  parameter int unsigned CNT_BITS  = LDTU_CNT_BITS,
  parameter int unsigned LOST_BITS = LDTU_LOST_BITS,
  parameter logic [W-1:0] INITIAL  = LDTU_INITIAL
) (
  input  logic                 CLK,
  input  logic                 rst_b,
  input  logic                 fallback,
  input  logic                 Load_data,
  input  logic [W-1:0]         DATA_in,
  input  logic                 Load_data_FB,
  input  logic [W-1:0]         DATA_FB,
  input  logic                 full,
  input  logic                 handshake,
  input  logic [CNT_BITS-1:0]  frame_len,
  output logic                 write_signal,
  output logic [W-1:0]         DATA_from_CU,
  output logic                 losing_data,
  output logic                 read_signal,
  output logic [LOST_BITS-1:0] lost_count,
  output logic [FBITS-1:0]     frame_count
);

  state_e              state;
  logic [CNT_BITS-1:0] cnt;
  logic [SBITS-1:0]    wt;
  logic [CRC_BITS-1:0] crc;
  logic                loss;

  logic [CRC_BITS-1:0]  crc_next_c;
  logic [5:0]           weight_c;
  logic [SBITS:0]       wt_sum_c;
  logic [SBITS-1:0]     wt_sat_c;
  logic [CNT_BITS-1:0]  cnt_inc_c;
  logic [CNT_BITS-1:0]  cnt_after_c;
  logic [CNT_BITS-1:0]  len_eff_c;
  logic [LOST_BITS-1:0] lost_inc_c;
  logic                 accept_c;
  logic                 drop_c;

  ldtu_crc_step u_crc (
    .data       (DATA_in),
    .crc        (crc),
    .crc_next_c (crc_next_c)
  );

  ldtu_sample_weight u_weight (
    .code     (DATA_in[W-1 -: 8]),
    .weight_c (weight_c)
  );

  // Saturating arithmetic and the effective frame length (0 behaves as 1).
  always_comb begin
    accept_c    = Load_data & ~full;
    drop_c      = Load_data & full;
    wt_sum_c    = {1'b0, wt} + (SBITS+1)'(weight_c);
    wt_sat_c    = wt_sum_c[SBITS] ? '1 : wt_sum_c[SBITS-1:0];
    cnt_inc_c   = (&cnt) ? cnt : cnt + CNT_BITS'(1);
    cnt_after_c = accept_c ? cnt_inc_c : cnt;
    len_eff_c   = (frame_len == '0) ? CNT_BITS'(1) : frame_len;
    lost_inc_c  = (&lost_count) ? lost_count : lost_count + LOST_BITS'(1);
  end

  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      state        <= COLLECT;
      cnt          <= '0;
      wt           <= '0;
      crc          <= '0;
      loss         <= 1'b0;
      write_signal <= 1'b0;
      DATA_from_CU <= INITIAL;
      losing_data  <= 1'b0;
      read_signal  <= 1'b0;
      lost_count   <= '0;
      frame_count  <= '0;
    end else begin
      write_signal <= 1'b0;
      losing_data  <= 1'b0;
      read_signal  <= handshake;
      if (fallback) begin
        // Frame state is held cleared; any pending trailer is abandoned.
        state       <= FB;
        cnt         <= '0;
        wt          <= '0;
        crc         <= '0;
        loss        <= 1'b0;
        frame_count <= '0;
        if (Load_data || Load_data_FB) begin
          if (!full) begin
            write_signal <= 1'b1;
            DATA_from_CU <= DATA_FB;
          end else begin
            losing_data <= 1'b1;
            lost_count  <= lost_inc_c;
          end
        end
      end else if (state == PEND && !Load_data) begin
        if (!full) begin
          write_signal <= 1'b1;
          DATA_from_CU <= {(loss ? ID_LOSS : ID_OK), wt, crc, frame_count};
          cnt          <= '0;
          wt           <= '0;
          crc          <= '0;
          loss         <= 1'b0;
          frame_count  <= frame_count + FBITS'(1);
          state        <= COLLECT;
        end
      end else begin
        // Data path shared by COLLECT, PEND and the first cycle after fallback.
        if (accept_c) begin
          write_signal <= 1'b1;
          DATA_from_CU <= DATA_in;
          cnt          <= cnt_inc_c;
          wt           <= wt_sat_c;
          crc          <= crc_next_c;
        end
        if (drop_c) begin
          losing_data <= 1'b1;
          lost_count  <= lost_inc_c;
          loss        <= 1'b1;
        end
        if (state != PEND) state <= (cnt_after_c >= len_eff_c) ? PEND : COLLECT;
      end
    end
  end

endmodule

// File: tb/tb_ldtu_framer_gen2.sv
// Self-checking bench for ldtu_framer_gen2: weight table, directed frame scenarios, cycle scoreboard.
module tb_ldtu_framer_gen2;

  logic        CLK = 1'b0;
  logic        rst_b, fallback, Load_data, Load_data_FB, full, handshake;
  logic [31:0] DATA_in, DATA_FB;
  logic [5:0]  frame_len;
  logic        write_signal, losing_data, read_signal;
  logic [31:0] DATA_from_CU;
  logic [15:0] lost_count;
  logic [7:0]  frame_count;

  always #5 CLK = ~CLK;

  ldtu_framer_gen2 dut (
    .CLK(CLK), .rst_b(rst_b), .fallback(fallback), .Load_data(Load_data),
    .DATA_in(DATA_in), .Load_data_FB(Load_data_FB), .DATA_FB(DATA_FB),
    .full(full), .handshake(handshake), .frame_len(frame_len),
    .write_signal(write_signal), .DATA_from_CU(DATA_from_CU),
    .losing_data(losing_data), .read_signal(read_signal),
    .lost_count(lost_count), .frame_count(frame_count)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        los;
    logic        rd;
    logic [15:0] lost;
    logic [7:0]  fc;
  } exp_t;

  typedef struct {
    logic [7:0] code;
    logic [7:0] wt;
  } wvec_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  int          n_wr  = 0;
  logic [31:0] last_wr = '0;
  logic [11:0] g_crc = '0;

  // Independent reference state
  int          m_st;
  logic [5:0]  m_cnt;
  logic [7:0]  m_wt;
  logic [11:0] m_crc;
  logic        m_loss;
  logic [7:0]  m_fno;
  logic [15:0] m_lost;
  logic [31:0] m_data;

  function automatic int tb_weight(input logic [7:0] code);
    if (code[7:6] == 2'b11) return 0;
    if (code[7:6] == 2'b10) return int'(code[5:0]);
    if (code[7:6] == 2'b01) return 5;
    return (code[7:2] == 6'h0A) ? 2 : 1;
  endfunction

  function automatic logic [11:0] tb_crc(input logic [31:0] d, input logic [11:0] c);
    logic [11:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      if (r[11] ^ d[i]) r = (r << 1) ^ 12'h80F;
      else              r = r << 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model(output exp_t e);
    int len;
    int tmp;
    e.wr  = 1'b0;
    e.los = 1'b0;
    e.rd  = handshake;
    len   = (frame_len == 6'd0) ? 1 : int'(frame_len);
    if (!rst_b) begin
      m_st = 0; m_cnt = '0; m_wt = '0; m_crc = '0; m_loss = 1'b0;
      m_fno = '0; m_lost = '0; m_data = 32'hF000_0000; e.rd = 1'b0;
    end else if (fallback) begin
      m_st = 2; m_cnt = '0; m_wt = '0; m_crc = '0; m_loss = 1'b0; m_fno = '0;
      if (Load_data || Load_data_FB) begin
        if (!full) begin e.wr = 1'b1; m_data = DATA_FB; end
        else begin e.los = 1'b1; if (m_lost != 16'hFFFF) m_lost = m_lost + 16'd1; end
      end
    end else if (m_st == 1 && !Load_data) begin
      if (!full) begin
        e.wr   = 1'b1;
        m_data = {(m_loss ? 4'hE : 4'hD), m_wt, m_crc, m_fno};
        m_cnt = '0; m_wt = '0; m_crc = '0; m_loss = 1'b0;
        m_fno = m_fno + 8'd1;
        m_st  = 0;
      end
    end else begin
      if (Load_data) begin
        if (!full) begin
          e.wr   = 1'b1;
          m_data = DATA_in;
          if (m_cnt != 6'd63) m_cnt = m_cnt + 6'd1;
          tmp  = int'(m_wt) + tb_weight(DATA_in[31:24]);
          m_wt = (tmp > 255) ? 8'hFF : 8'(tmp);
          m_crc = tb_crc(DATA_in, m_crc);
        end else begin
          e.los  = 1'b1;
          m_loss = 1'b1;
          if (m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
        end
      end
      if (m_st != 1) m_st = (int'(m_cnt) >= len) ? 1 : 0;
    end
    e.data = m_data;
    e.lost = m_lost;
    e.fc   = m_fno;
  endtask

  // One clock: drive inputs, predict, then compare every output 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic fb, input logic ld, input logic [31:0] d,
                     input logic ldfb, input logic [31:0] dfb, input logic fl);
    exp_t e;
    rst_b = rst; fallback = fb; Load_data = ld; DATA_in = d;
    Load_data_FB = ldfb; DATA_FB = dfb; full = fl; handshake = 1'($urandom);
    model(e);
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    chk("sb_write", 32'(write_signal), 32'(e.wr));
    chk("sb_data",  DATA_from_CU,      e.data);
    chk("sb_losing", 32'(losing_data), 32'(e.los));
    chk("sb_read",  32'(read_signal),  32'(e.rd));
    chk("sb_lost",  32'(lost_count),   32'(e.lost));
    chk("sb_frame", 32'(frame_count),  32'(e.fc));
    if (write_signal) begin
      n_wr++;
      last_wr = DATA_from_CU;
    end
  endtask

  task automatic word(input logic [7:0] code, input logic fl);
    logic [31:0] d;
    d = {code, 24'($urandom)};
    cyc(1'b1, 1'b0, 1'b1, d, 1'b0, '0, fl);
    if (!fl) g_crc = tb_crc(d, g_crc);
  endtask

  task automatic idle(input logic fl);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, fl);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    g_crc = '0;
  endtask

  wvec_t wtab[10];
  int    n0;
  logic [31:0] dfb;

  initial begin
    rst_b = 1'b0; fallback = 1'b0; Load_data = 1'b0; Load_data_FB = 1'b0;
    DATA_in = '0; DATA_FB = '0; full = 1'b0; handshake = 1'b0; frame_len = 6'd0;

    wtab[0] = '{8'h45, 8'd5};  wtab[1] = '{8'h80, 8'd0};  wtab[2] = '{8'hBF, 8'd63};
    wtab[3] = '{8'h95, 8'd21}; wtab[4] = '{8'h28, 8'd2};  wtab[5] = '{8'h2B, 8'd2};
    wtab[6] = '{8'h2C, 8'd1};  wtab[7] = '{8'h00, 8'd1};  wtab[8] = '{8'hC3, 8'd0};
    wtab[9] = '{8'h7F, 8'd5};

    // Reset values
    do_reset();
    chk("rst_data",  DATA_from_CU, 32'hF000_0000);
    chk("rst_write", 32'(write_signal), 32'd0);
    chk("rst_frame", 32'(frame_count), 32'd0);

    // One-word frames with frame_len=0 (treated as 1): weight table
    frame_len = 6'd0;
    for (int i = 0; i < 10; i++) begin
      g_crc = '0;
      n0 = n_wr;
      word(wtab[i].code, 1'b0);
      idle(1'b0);
      chk("tab_writes", 32'(n_wr - n0), 32'd2);
      chk("tab_id",     32'(last_wr[31:28]), 32'hD);
      chk("tab_weight", 32'(last_wr[27:20]), 32'(wtab[i].wt));
      chk("tab_crc",    32'(last_wr[19:8]),  32'(g_crc));
      chk("tab_fno",    32'(last_wr[7:0]),   32'(i));
    end

    // Nominal 50-word frame
    do_reset();
    frame_len = 6'd50;
    n0 = n_wr;
    for (int i = 0; i < 50; i++) word(8'h45, 1'b0);
    idle(1'b0);
    chk("nom_writes", 32'(n_wr - n0), 32'd51);
    chk("nom_id",     32'(last_wr[31:28]), 32'hD);
    chk("nom_weight", 32'(last_wr[27:20]), 32'hFA);
    chk("nom_crc",    32'(last_wr[19:8]),  32'(g_crc));
    chk("nom_fno",    32'(last_wr[7:0]),   32'd0);
    chk("nom_fcount", 32'(frame_count),    32'd1);

    // Drop on load 10
    do_reset();
    frame_len = 6'd49;
    for (int i = 0; i < 50; i++) begin
      word(8'h45, i == 9);
      if (i == 9)  chk("drop_losing", 32'(losing_data), 32'd1);
      if (i == 10) chk("drop_losing_clr", 32'(losing_data), 32'd0);
    end
    idle(1'b0);
    chk("drop_lost",   32'(lost_count),       32'd1);
    chk("drop_id",     32'(last_wr[31:28]),   32'hE);
    chk("drop_weight", 32'(last_wr[27:20]),   32'hF5);
    chk("drop_crc",    32'(last_wr[19:8]),    32'(g_crc));

    // Trailer held by full
    do_reset();
    frame_len = 6'd50;
    for (int i = 0; i < 50; i++) word(8'h45, 1'b0);
    n0 = n_wr;
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("full_nowrite", 32'(n_wr - n0), 32'd0);
    idle(1'b0);
    chk("full_trl_wr", 32'(write_signal), 32'd1);
    chk("full_trl_id", 32'(DATA_from_CU[31:28]), 32'hD);
    chk("full_trl_crc", 32'(DATA_from_CU[19:8]), 32'(g_crc));
    chk("full_nolost", 32'(lost_count), 32'd0);

    // Weight saturation and frame-number wrap
    do_reset();
    frame_len = 6'd5;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 5; i++) word(8'hBF, 1'b0);
      idle(1'b0);
      if (f == 0) chk("sat_weight", 32'(last_wr[27:20]), 32'hFF);
    end
    chk("wrap_last_fno", 32'(last_wr[7:0]), 32'hFF);
    chk("wrap_fcount",   32'(frame_count),  32'd0);

    // Fallback mid-frame
    do_reset();
    frame_len = 6'd50;
    for (int i = 0; i < 20; i++) word(8'h45, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dfb = $urandom;
      cyc(1'b1, 1'b1, (i == 2), {8'h45, 24'(i)}, (i != 2), dfb, 1'b0);
      chk("fb_write", 32'(write_signal), 32'd1);
      chk("fb_data",  DATA_from_CU, dfb);
    end
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h1234_5678, 1'b1);
    chk("fb_drop_lost", 32'(lost_count), 32'd1);
    chk("fb_fcount", 32'(frame_count), 32'd0);
    idle(1'b0);
    chk("fb_exit_nowrite", 32'(write_signal), 32'd0);
    g_crc = '0;
    n0 = n_wr;
    for (int i = 0; i < 50; i++) word(8'h45, 1'b0);
    idle(1'b0);
    chk("fb_next_writes", 32'(n_wr - n0), 32'd51);
    chk("fb_next_id",     32'(last_wr[31:28]), 32'hD);
    chk("fb_next_weight", 32'(last_wr[27:20]), 32'hFA);
    chk("fb_next_fno",    32'(last_wr[7:0]),   32'd0);

    // Reset mid-frame with a load present
    do_reset();
    frame_len = 6'd50;
    for (int i = 0; i < 30; i++) word(8'h45, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h4500_0001, 1'b0, '0, 1'b0);
    g_crc = '0;
    chk("mrst_data",   DATA_from_CU, 32'hF000_0000);
    chk("mrst_write",  32'(write_signal), 32'd0);
    chk("mrst_read",   32'(read_signal),  32'd0);
    chk("mrst_losing", 32'(losing_data),  32'd0);
    n0 = n_wr;
    for (int i = 0; i < 49; i++) word(8'h45, 1'b0);
    idle(1'b0);
    chk("mrst_no_trailer", 32'(n_wr - n0), 32'd49);
    word(8'h45, 1'b0);
    idle(1'b0);
    chk("mrst_trailer_wr", 32'(n_wr - n0), 32'd51);
    chk("mrst_trailer_id", 32'(last_wr[31:28]), 32'hD);
    chk("mrst_trailer_crc", 32'(last_wr[19:8]), 32'(g_crc));

    // frame_len lowered mid-frame closes the frame early
    do_reset();
    frame_len = 6'd50;
    for (int i = 0; i < 10; i++) word(8'h45, 1'b0);
    frame_len = 6'd3;
    idle(1'b0);
    chk("len_chg_nowrite", 32'(write_signal), 32'd0);
    idle(1'b0);
    chk("len_chg_trailer", 32'(write_signal), 32'd1);
    chk("len_chg_weight",  32'(DATA_from_CU[27:20]), 32'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldtu_framer_gen2.md
# ldtu_framer_gen2

Parametrised second-generation framing control unit for the LiteDTU output path. It sits between the compression/baseline stage and the output FIFO. It forwards each compressed word, or each fallback word, to the FIFO. In normal mode it closes every frame with a trailer word carrying four fields: sample weight, CRC, frame number and a loss flag. Frame length is a runtime input rather than a fixed constant. Loss is counted and reported per frame.

## Interface

Parameters:
- `W`, 32: data word width; must equal 4+`SBITS`+`CRC_BITS`+`FBITS`.
- `SBITS`, 8: sample-weight accumulator width.
- `CRC_BITS`, 12: CRC width.
- `FBITS`, 8: frame-number width.
- `CNT_BITS`, 6: frame word counter width.
- `LOST_BITS`, 16: lost-word counter width.
- `INITIAL`, 32'hF000_0000: reset value of `DATA_from_CU`.

Ports:
- `CLK`  in  1  sole clock; all logic on the rising edge.
- `rst_b`  in  1  synchronous, active-low reset.
- `fallback`  in  1  1 selects fallback mode: no framing, `DATA_FB` is forwarded.
- `Load_data`  in  1  `DATA_in` valid this cycle.
- `DATA_in`  in  `W`  compressed word; bits [W-1:W-8] carry the type/sample code.
- `Load_data_FB`  in  1  `DATA_FB` valid this cycle.
- `DATA_FB`  in  `W`  fallback word.
- `full`  in  1  FIFO full.
- `handshake`  in  1  readout request.
- `frame_len`  in  `CNT_BITS`  words per frame, quasi-static; 0 is treated as 1.
- `write_signal`  out  1  FIFO write strobe.
- `DATA_from_CU`  out  `W`  word to FIFO.
- `losing_data`  out  1  a word was dropped last cycle.
- `read_signal`  out  1  registered `handshake`.
- `lost_count`  out  `LOST_BITS`  saturating count of dropped words since reset.
- `frame_count`  out  `FBITS`  current frame number.

## Operation

All outputs are registered. Reset values: `DATA_from_CU`=`INITIAL`; every other output is 0. Reset clears all counters and the CRC, and sets the state to COLLECT. Reset takes priority over every other event.

States:
- **COLLECT**
  - `Load_data`=1 and `full`=0: forward `DATA_in` with `write_signal`=1. Then:
    - word count +1 (saturating);
    - weight accumulator += weight(`DATA_in`), saturating at 2^`SBITS`-1;
    - `crc` <= crc_next(`DATA_in`, `crc`).
  - `Load_data`=1 and `full`=1: drop the word. `losing_data`=1, `lost_count`+1 (saturating), frame loss flag set. CRC and counters are unchanged.
  - When count ≥ max(`frame_len`,1), go to PEND.
- **PEND**
  - Incoming data keeps priority and is handled exactly as in COLLECT; the frame may grow.
  - On the first cycle with `Load_data`=0 and `full`=0:
    - write trailer {ID, weight, crc, frame_no}; ID=4'b1101, or 4'b1110 if the loss flag is set;
    - clear count, weight, crc and loss flag;
    - frame_no+1 (wraps);
    - go to COLLECT.
  - `full`=1 holds the trailer pending with `write_signal`=0. The trailer itself is never lost.
- **FB** (entered whenever `fallback`=1, from any state)
  - Count, weight, crc, loss flag and frame_no are held at 0.
  - `Load_data_FB`=1 or `Load_data`=1, with `full`=0: write `DATA_FB`.
  - The same load with `full`=1: loss handling as in COLLECT; the loss flag stays 0.
  - `fallback`=0 returns to COLLECT with cleared frame state.

Weight:
- code[7:6]=01 → 5
- code[7:6]=10 → {0,code[5:0]}
- code[7:6]=00 → 2 if code[7:2]=6'b001010, else 1
- code[7:6]=11 → 0

`losing_data` returns to 0 on any cycle without a dropped word. `read_signal` equals `handshake` delayed by one cycle.

## Timing

- Latency from input to output is 1 cycle for data, trailer, `losing_data` and `read_signal`.
- `write_signal` is a single-cycle strobe per word. Back-to-back writes are allowed every cycle.
- The trailer appears at the earliest 1 cycle after the first idle, non-full cycle once count ≥ `frame_len`.
- `fallback` takes effect on the next edge. A pending trailer is discarded on entry to FB.
- `frame_len` changed mid-frame: the new value is compared from the next cycle on.

## Structure

- Shared package `ldtu_pkg`:
  - state enum {COLLECT, PEND, FB};
  - trailer IDs 4'b1101 and 4'b1110;
  - `INITIAL`;
  - default widths;
  - the constant CRC-12 XOR matrix. Keep the existing LiteDTU equations; the CRC output is 0 under reset.
- Sub-modules:
  - `ldtu_crc_step`: combinational next-CRC.
  - `ldtu_sample_weight`: combinational weight.

## Test plan

- **Nominal frame:** `frame_len`=50; 50 loads with code 8'h45, then idle. Expect 50 writes, then trailer ID 1101 with weight 8'hFA (50 × 5), crc equal to the golden model, frame_no 0; `frame_count`→1.
- **Drop:** `full`=1 during load 10 of a frame. Expect `losing_data`=1 for 1 cycle, `lost_count`=1, crc skipping that word, and the trailer with ID 1110 and 49 weights.
- **Trailer under full:** `full`=1 held for 5 cycles after the 50th word. Expect no write during those cycles and the trailer exactly 1 cycle after `full` falls; no loss reported.
- **Saturation/wrap:** 256 frames with code 8'hBF (weight 63). Expect weight saturating at 8'hFF and frame_no wrapping 255→0.
- **Fallback mid-frame:** `fallback`=1 after 20 words. Expect `DATA_FB` forwarded, no trailer; on exit, the next frame starts with frame_no 0 and count 0.
- **Reset mid-frame:** `rst_b`=0 for 1 cycle after 30 words. Expect `DATA_from_CU`=32'hF000_0000, all other outputs 0, and the next trailer only after 50 new words.
